// File: rtl/y86_mc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : y86_mc_ctrl
// Purpose  : Multi-cycle Y86 sequencer. It steps each instruction through
//            FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK and PCUPD. It also
//            issues the write strobes, drives the data-memory handshake with a
//            timeout, tracks Y86 status and keeps saturating cycle and
//            instruction counters.
// Ports    : clk, rst_n             - clock, async active-low reset
//            start_i                - start/restart (IDLE or HALT only)
//            icode_i                - instruction code
//            imem_error_i           - fetch address error
//            cnd_i                  - execute condition (not used here)
//            next_pc_i              - PC from PC-select logic
//            dmem_ack_i/_error_i    - data memory completion / error
//            pc_o, state_o, stat_o  - architectural PC, FSM state, status
//            dmem_req_o             - data memory request
//            en_cc_o/en_reg_o/en_pc_o - one-cycle write strobes
//            busy_o                 - not IDLE and not HALT
//            cycle_cnt_o/instr_cnt_o - saturating counters
// Revision : 1.0 - initial release
// ============================================================================
module y86_mc_ctrl #(
  parameter int                ADDR_W      = 64,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0,
  parameter int                CNT_W       = 32,
  parameter int                MEM_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [3:0]        icode_i,
  input  logic              imem_error_i,
  input  logic              cnd_i,
  input  logic [ADDR_W-1:0] next_pc_i,
  input  logic              dmem_ack_i,
  input  logic              dmem_error_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic [2:0]        state_o,
  output logic              dmem_req_o,
  output logic              en_cc_o,
  output logic              en_reg_o,
  output logic              en_pc_o,
  output logic [2:0]        stat_o,
  output logic              busy_o,
  output logic [CNT_W-1:0]  cycle_cnt_o,
  output logic [CNT_W-1:0]  instr_cnt_o
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_MEMORY    = 3'd4,
    S_WRITEBACK = 3'd5,
    S_PCUPD     = 3'd6,
    S_HALT      = 3'd7
  } state_e;

  localparam logic [2:0] c_stat_aok = 3'd1;
  localparam logic [2:0] c_stat_hlt = 3'd2;
  localparam logic [2:0] c_stat_adr = 3'd3;
  localparam logic [2:0] c_stat_ins = 3'd4;

  // Counter must be able to hold MEM_TIMEOUT-1.
  localparam int             TO_W      = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [TO_W-1:0] c_to_last = TO_W'(MEM_TIMEOUT - 1);

  state_e              state_q;
  logic [ADDR_W-1:0]   pc_q;
  logic [2:0]          stat_q;
  logic                dmem_req_q;
  logic                en_cc_q;
  logic                en_reg_q;
  logic                en_pc_q;
  logic [TO_W-1:0]     mem_cnt_q;
  logic [CNT_W-1:0]    cycle_cnt_q;
  logic [CNT_W-1:0]    instr_cnt_q;
  logic [CNT_W-1:0]    cycle_cnt_d;
  logic [CNT_W-1:0]    instr_cnt_d;
  logic                busy;
  logic                is_mem;
  logic                is_reg;
  logic                cnd_unused;

  // The condition flag is consumed by PC-select logic outside this block.
  assign cnd_unused = cnd_i;

  assign busy   = (state_q != S_IDLE) && (state_q != S_HALT);
  assign is_mem = (icode_i inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB});
  assign is_reg = (icode_i inside {4'h2, 4'h3, 4'h5, 4'h6, 4'h8, 4'h9, 4'hA, 4'hB});

  // Saturating increments: both counters stick at all-ones.
  assign cycle_cnt_d = (cycle_cnt_q == '1) ? cycle_cnt_q : cycle_cnt_q + CNT_W'(1);
  assign instr_cnt_d = (instr_cnt_q == '1) ? instr_cnt_q : instr_cnt_q + CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      stat_q      <= c_stat_aok;
      dmem_req_q  <= 1'b0;
      en_cc_q     <= 1'b0;
      en_reg_q    <= 1'b0;
      en_pc_q     <= 1'b0;
      mem_cnt_q   <= '0;
      cycle_cnt_q <= '0;
      instr_cnt_q <= '0;
    end else begin
      // Strobes are single-cycle; each is raised only on entry to its state.
      en_cc_q  <= 1'b0;
      en_reg_q <= 1'b0;
      en_pc_q  <= 1'b0;
      if (busy) begin
        cycle_cnt_q <= cycle_cnt_d;
      end
      case (state_q)
        S_IDLE, S_HALT: begin
          if (start_i) begin
            pc_q    <= RESET_PC;
            stat_q  <= c_stat_aok;
            state_q <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (imem_error_i) begin
            stat_q  <= c_stat_adr;
            state_q <= S_HALT;
          end else begin
            state_q <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (icode_i > 4'hB) begin
            stat_q  <= c_stat_ins;
            state_q <= S_HALT;
          end else if (icode_i == 4'h0) begin
            // halt retires as an instruction but leaves pc alone
            stat_q      <= c_stat_hlt;
            state_q     <= S_HALT;
            instr_cnt_q <= instr_cnt_d;
          end else begin
            en_cc_q <= (icode_i == 4'h6);
            state_q <= S_EXECUTE;
          end
        end
        S_EXECUTE: begin
          dmem_req_q <= is_mem;
          mem_cnt_q  <= '0;
          state_q    <= S_MEMORY;
        end
        S_MEMORY: begin
          if (!dmem_req_q) begin
            en_reg_q <= is_reg;
            state_q  <= S_WRITEBACK;
          end else if (dmem_ack_i) begin
            dmem_req_q <= 1'b0;
            if (dmem_error_i) begin
              stat_q  <= c_stat_adr;
              state_q <= S_HALT;
            end else begin
              en_reg_q <= is_reg;
              state_q  <= S_WRITEBACK;
            end
          end else if (mem_cnt_q == c_to_last) begin
            // this was the MEM_TIMEOUT-th request cycle without an ack
            dmem_req_q <= 1'b0;
            stat_q     <= c_stat_adr;
            state_q    <= S_HALT;
          end else begin
            mem_cnt_q <= mem_cnt_q + TO_W'(1);
          end
        end
        S_WRITEBACK: begin
          en_pc_q <= 1'b1;
          state_q <= S_PCUPD;
        end
        S_PCUPD: begin
          pc_q        <= next_pc_i;
          instr_cnt_q <= instr_cnt_d;
          state_q     <= S_FETCH;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign pc_o        = pc_q;
  assign state_o     = state_q;
  assign dmem_req_o  = dmem_req_q;
  assign en_cc_o     = en_cc_q;
  assign en_reg_o    = en_reg_q;
  assign en_pc_o     = en_pc_q;
  assign stat_o      = stat_q;
  assign busy_o      = busy;
  assign cycle_cnt_o = cycle_cnt_q;
  assign instr_cnt_o = instr_cnt_q;

endmodule
`default_nettype wire

// File: doc/y86_mc_ctrl.md
Y86_MC_CTRL -- requirements
Module: y86_mc_ctrl

Interface
REQ-001 Parameter ADDR_W, default 64: width of pc and next_pc.
REQ-002 Parameter RESET_PC, default 0: pc value loaded on start.
REQ-003 Parameter CNT_W, default 32: width of cycle_cnt and instr_cnt.
REQ-004 Parameter MEM_TIMEOUT, default 16: maximum MEMORY-state cycles waiting for dmem_ack.
REQ-005 clk  in  1  single clock; all state changes on rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 start  in  1  begin or restart execution; honoured only in IDLE or HALT.
REQ-008 icode  in  4  instruction code from fetch split logic.
REQ-009 imem_error  in  1  instruction fetch address error.
REQ-010 cnd  in  1  condition result from execute; informational, forwarded to no output.
REQ-011 next_pc  in  ADDR_W  new PC computed by PC-select logic.
REQ-012 dmem_ack  in  1  data memory access complete.
REQ-013 dmem_error  in  1  data memory error, valid with dmem_ack.
REQ-014 pc  out  ADDR_W  architectural program counter.
REQ-015 state  out  3  current FSM state encoding.
REQ-016 dmem_req  out  1  data memory request, held until ack or timeout.
REQ-017 en_cc  out  1  one-cycle condition-code write strobe.
REQ-018 en_reg  out  1  one-cycle register-file write strobe.
REQ-019 en_pc  out  1  one-cycle strobe, high in the cycle pc loads next_pc.
REQ-020 stat  out  3  Y86 status: 1 AOK, 2 HLT, 3 ADR, 4 INS.
REQ-021 busy  out  1  high in every state except IDLE and HALT.
REQ-022 cycle_cnt  out  CNT_W  cycles spent busy, saturating.
REQ-023 instr_cnt  out  CNT_W  instructions retired, saturating.

Function
REQ-024 States and encodings: IDLE 0, FETCH 1, DECODE 2, EXECUTE 3, MEMORY 4, WRITEBACK 5, PCUPD 6, HALT 7.
REQ-025 Sequence: FETCH -> DECODE -> EXECUTE -> MEMORY -> WRITEBACK -> PCUPD -> FETCH; each non-MEMORY state lasts exactly one cycle.
REQ-026 IDLE or HALT with start=1: pc <= RESET_PC, stat <= AOK, next state FETCH; counters are not cleared.
REQ-027 FETCH with imem_error=1: stat <= ADR, next state HALT.
REQ-028 DECODE with icode > 0xB: stat <= INS, next state HALT.
REQ-029 DECODE with icode = 0x0: stat <= HLT, next state HALT; pc unchanged; instr_cnt increments.
REQ-030 en_cc is high in EXECUTE only when icode = 0x6.
REQ-031 Memory icodes are 0x4, 0x5, 0x8, 0x9, 0xA and 0xB.
- Memory icode: dmem_req is high for every MEMORY cycle until dmem_ack=1 is sampled; ack is accepted in the same cycle req is first high.
- Non-memory icode: MEMORY lasts one cycle and dmem_req stays low.
REQ-032 dmem_ack=1 with dmem_error=1: stat <= ADR, next state HALT; no en_reg, no en_pc.
REQ-033 MEMORY timeout: MEM_TIMEOUT consecutive req cycles without ack -> stat <= ADR, next state HALT; dmem_req drops on the next edge.
REQ-034 dmem_ack outside MEMORY, or while dmem_req is low, is ignored.
REQ-035 en_reg is high in WRITEBACK for icodes 0x2, 0x3, 0x5, 0x6, 0x8, 0x9, 0xA and 0xB.
REQ-036 PCUPD: en_pc=1, pc <= next_pc, instr_cnt increments, next state FETCH.
REQ-037 Latency: non-memory instruction takes 6 cycles FETCH to FETCH; memory instruction takes 6 + (ack cycle index − 1).
REQ-038 cycle_cnt increments every cycle busy=1; both counters hold at 2^CNT_W−1.
REQ-039 start is ignored while busy=1.

Reset
REQ-040 rst_n low asynchronously forces, at any point including mid-MEMORY:
- state IDLE; pc RESET_PC; stat AOK;
- all strobes and dmem_req 0;
- cycle_cnt and instr_cnt 0.
REQ-041 After rst_n deasserts, the block stays in IDLE until start.

Verification
REQ-042 start; icode 0x6; next_pc=0x2 -> en_cc in cycle 3, en_reg in cycle 5, en_pc in cycle 6, pc=0x2, instr_cnt=1.
REQ-043 icode 0x5; ack on 3rd MEMORY cycle -> dmem_req high 3 cycles, 8-cycle instruction, en_reg=1.
REQ-044 icode 0xA; no ack with MEM_TIMEOUT=4 -> dmem_req 4 cycles, stat=3, state=7, pc unchanged.
REQ-045 icode 0xC -> stat=4, HALT; icode 0x0 -> stat=2, HALT, instr_cnt+1; start from HALT -> pc=RESET_PC, stat=1.
REQ-046 FETCH with imem_error=1 -> stat=3; rst_n pulsed low mid-MEMORY -> immediate IDLE, dmem_req=0, counters=0.
REQ-047 CNT_W=4; run 20 busy cycles -> cycle_cnt=15, held.
